// File: rtl/if_instr_fifo_pkg.sv
// Shared fetch-queue types and constants for the IF stage.
package if_instr_fifo_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } IFQ_Entry_t;

  localparam int unsigned IFQ_DEPTH = 4;
  localparam logic [31:0] NOP_WORD  = 32'b0;

endpackage

// File: rtl/if_instr_fifo.sv
// First-word fall-through prefetch queue between I-cache read data and the IF/ID register.
// A flush discards the queue contents and any push or pop in the same cycle.
module if_instr_fifo
  import if_instr_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_Flush,
  input  logic        Cache_Valid,
  input  logic [31:0] Cache_PC,
  input  logic [31:0] Cache_Instr,
  input  logic        Cache_AdEL,
  output logic        Fifo_Full,
  input  logic        ID_Wr,
  output logic        IF_Valid,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_Instr,
  output logic        IF_AdEL
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  IFQ_Entry_t       mem [DEPTH];
  IFQ_Entry_t       head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;

  // Full comes only from the registered count, so a same-cycle pop never admits a push.
  assign Fifo_Full = (count == CNT_FULL);
  assign IF_Valid  = (count != '0);
  assign push      = Cache_Valid && !Fifo_Full && !IF_Flush;
  assign pop       = ID_Wr && IF_Valid && !IF_Flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (IF_Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: Cache_PC, instr: Cache_Instr, adel: Cache_AdEL};
  end

  always_comb begin
    head     = mem[rd_ptr];
    IF_PC    = '0;
    IF_Instr = NOP_WORD;
    IF_AdEL  = 1'b0;
    if (IF_Valid) begin
      IF_PC    = head.pc;
      IF_Instr = head.instr;
      IF_AdEL  = head.adel;
    end
  end

endmodule

// File: tb/tb_if_instr_fifo.sv
// Scoreboard bench for if_instr_fifo: driver queues expected entries, a forked monitor
// compares the head against the queue whenever ID captures a valid entry.
module tb_if_instr_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_Flush;
  logic        Cache_Valid;
  logic [31:0] Cache_PC;
  logic [31:0] Cache_Instr;
  logic        Cache_AdEL;
  logic        Fifo_Full;
  logic        ID_Wr;
  logic        IF_Valid;
  logic [31:0] IF_PC;
  logic [31:0] IF_Instr;
  logic        IF_AdEL;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mcnt   = 0;

  if_instr_fifo #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .IF_Flush    (IF_Flush),
    .Cache_Valid (Cache_Valid),
    .Cache_PC    (Cache_PC),
    .Cache_Instr (Cache_Instr),
    .Cache_AdEL  (Cache_AdEL),
    .Fifo_Full   (Fifo_Full),
    .ID_Wr       (ID_Wr),
    .IF_Valid    (IF_Valid),
    .IF_PC       (IF_PC),
    .IF_Instr    (IF_Instr),
    .IF_AdEL     (IF_AdEL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: drive inputs, queue the expected entry if the push should be accepted,
  // advance the occupancy model, then check the status outputs just after the edge.
  task automatic cyc(input logic v, input logic [31:0] pc, input logic adel,
                     input logic idwr, input logic flush, input logic acc);
    Cache_Valid = v;
    Cache_PC    = pc;
    Cache_Instr = pc ^ 32'hA5A5_0000;
    Cache_AdEL  = adel;
    ID_Wr       = idwr;
    IF_Flush    = flush;
    if (v && acc && !flush) exp_q.push_back('{pc: pc, instr: pc ^ 32'hA5A5_0000, adel: adel});
    @(posedge clk);
    #1;
    if (flush) begin
      exp_q.delete();
      mcnt = 0;
    end else begin
      mcnt = mcnt + ((v && acc) ? 1 : 0) - ((idwr && mcnt > 0) ? 1 : 0);
    end
    Cache_Valid = 1'b0;
    ID_Wr       = 1'b0;
    IF_Flush    = 1'b0;
    chk("full_flag",  32'(Fifo_Full), 32'(mcnt == 4));
    chk("valid_flag", 32'(IF_Valid),  32'(mcnt != 0));
    if (mcnt == 0) begin
      chk("empty_pc",    IF_PC,    32'h0);
      chk("empty_instr", IF_Instr, 32'h0);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic acc);
    cyc(1'b1, pc, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic pop();
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; IF_Flush = 1'b0; Cache_Valid = 1'b0; Cache_PC = '0;
    Cache_Instr = '0; Cache_AdEL = 1'b0; ID_Wr = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && ID_Wr && !IF_Flush && IF_Valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got pc %h expected no entry at %0t", IF_PC, $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("head_pc",    IF_PC,         e.pc);
            chk("head_instr", IF_Instr,      e.instr);
            chk("head_adel",  32'(IF_AdEL),  32'(e.adel));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(IF_Valid),  32'h0);
    chk("rst_full",  32'(Fifo_Full), 32'h0);
    chk("rst_instr", IF_Instr,       32'h0);
    chk("rst_pc",    IF_PC,          32'h0);
    rst = 1'b0;

    // Fill to full, reject fifth push, drain in order.
    push(32'h0, 1'b1);
    push(32'h4, 1'b1);
    push(32'h8, 1'b1);
    chk("fill_not_full", 32'(Fifo_Full), 32'h0);
    push(32'hC, 1'b1);
    chk("fill_full", 32'(Fifo_Full), 32'h1);
    push(32'h10, 1'b0);
    chk("fill_still_full", 32'(Fifo_Full), 32'h1);
    chk("fill_head", IF_PC, 32'h0);
    repeat (4) pop();
    chk("fill_drained", 32'(IF_Valid), 32'h0);
    pop();

    // Streaming: push and pop every cycle from empty, occupancy stays at one.
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1, 32'h40 + 32'(4 * k), 1'b0, 1'b1, 1'b0, 1'b1);
      chk("stream_pc", IF_PC, 32'h40 + 32'(4 * k));
    end
    pop();

    // Full with simultaneous pop and push: push rejected, count drops to 3.
    push(32'h30, 1'b1);
    push(32'h34, 1'b1);
    push(32'h38, 1'b1);
    push(32'h3C, 1'b1);
    cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("fullpop_head", IF_PC, 32'h34);
    repeat (3) pop();
    chk("fullpop_no_0x20", 32'(IF_Valid), 32'h0);

    // Flush beats same-cycle push and pop.
    push(32'h50, 1'b1);
    push(32'h54, 1'b1);
    cyc(1'b1, 32'h58, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("flush_valid", 32'(IF_Valid), 32'h0);
    push(32'h100, 1'b1);
    chk("flush_next_head", IF_PC, 32'h100);
    pop();

    // Wrap-around: ten entries through the four slots, AdEL marked on 0x1A.
    push(32'h10, 1'b1);
    push(32'h12, 1'b1);
    for (int k = 2; k < 10; k++) begin
      logic [31:0] pc;
      pc = 32'h10 + 32'(2 * k);
      cyc(1'b1, pc, pc == 32'h1A, 1'b1, 1'b0, 1'b1);
    end
    pop();
    pop();

    // Async reset with three entries queued, checked before any clock edge.
    push(32'h200, 1'b1);
    push(32'h204, 1'b1);
    push(32'h208, 1'b1);
    chk("pre_rst_valid", 32'(IF_Valid), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(IF_Valid),  32'h0);
    chk("async_rst_instr", IF_Instr,       32'h0);
    chk("async_rst_full",  32'(Fifo_Full), 32'h0);
    exp_q.delete();
    mcnt = 0;
    #1 rst = 1'b0;
    push(32'h300, 1'b1);
    chk("post_rst_head", IF_PC, 32'h300);
    pop();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
